req_capture_server: RTL and testbench

- Upstream request-capture stage feeding the 2**N-line priority encoder.
- Latches single-cycle request pulses into sticky pending bits.
- Serves pending bits one at a time, highest index first, by presenting a registered one-hot vector and its encoded index through a valid/ready handshake.
- Clears each bit once it is served, so no request is lost while the downstream stage stalls.

---
 rtl/req_capture_server.sv | 113 +++++++++++
 tb/tb_req_capture_server.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/req_capture_server.sv
// Sticky request capture feeding the 2**N-line priority encoder: serves pending
// lines highest index first over a valid/ready output. Optional DROP_CNT_EN adds drop_cnt.
module req_capture_server #(
    parameter int N = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [2**N-1:0] req,
    output logic [2**N-1:0] inVal,
    output logic [N-1:0]   out_index,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy,
`ifdef DROP_CNT_EN
    output logic [7:0]     drop_cnt,
`endif
    output logic           dbg_state
);
    localparam int W = 2**N;

    // Handshake: a line transfers on every rising edge where out_valid & out_ready;
    // while out_valid is high and out_ready low, inVal/out_index stay bit-stable.
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t         state_q;
    logic [W-1:0]   pending_q, pending_d;
    logic [W-1:0]   inval_q;
    logic [N-1:0]   index_q;
    logic           valid_q;
    logic [N-1:0]   sel_idx;
    logic [W-1:0]   sel_oh;
    logic [W-1:0]   clr;
    logic           load;

    // Last set bit seen in an ascending scan is the highest pending index.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (pending_q[i]) sel_idx = i[N-1:0];
        end
    end

    assign sel_oh    = {{(W-1){1'b0}}, 1'b1} << sel_idx;
    assign load      = enable && (|pending_q) && ((state_q == IDLE) || out_ready);
    assign clr       = load ? sel_oh : '0;
    assign pending_d = enable ? ((pending_q & ~clr) | req) : pending_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            inval_q   <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        inval_q <= sel_oh;
                        index_q <= sel_idx;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (load) begin
                        inval_q <= sel_oh;
                        index_q <= sel_idx;
                    end else if (out_ready) begin
                        inval_q <= '0;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign inVal     = inval_q;
    assign out_index = index_q;
    assign out_valid = valid_q;
    assign busy      = (|pending_q) | valid_q;
    assign dbg_state = state_q;

`ifdef DROP_CNT_EN
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic [W-1:0] dup;
    logic [15:0] dup_pop;
    logic [15:0] drop_sum;

    // A duplicate is a req landing on a bit that stays pending through this edge.
    assign dup = enable ? (req & pending_q & ~clr) : '0;

    always_comb begin
        dup_pop = '0;
        for (int i = 0; i < W; i++) begin
            dup_pop = dup_pop + {15'd0, dup[i]};
        end
        drop_sum   = {8'd0, drop_cnt_q} + dup_pop;
        drop_cnt_d = (drop_sum > 16'd255) ? 8'd255 : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_req_capture_server.sv
// Directed bench for req_capture_server: expected indices go into a queue as
// requests are issued; a negedge monitor pops and compares on every transfer.
module tb_req_capture_server;
    localparam int N = 3;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           enable;
    logic [W-1:0]   req;
    logic [W-1:0]   inVal;
    logic [N-1:0]   out_index;
    logic           out_valid;
    logic           out_ready;
    logic           busy;
    logic           dbg_state;
`ifdef DROP_CNT_EN
    logic [7:0]     drop_cnt;
`endif

    logic [N-1:0]   exp_q[$];
    int             checks;
    int             failures;

    req_capture_server #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .inVal     (inVal),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
`ifdef DROP_CNT_EN
        .drop_cnt  (drop_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge; checks happen there too.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic [W-1:0] r, input int cycles = 1);
        req = r;
        step(cycles);
        req = '0;
    endtask

    task automatic drain();
        int budget;
        budget = 60;
        while (exp_q.size() != 0 && budget > 0) begin
            step();
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: samples at negedge, where inputs and outputs are settled.
    always @(negedge clk) begin
        logic [N-1:0] e;
        logic [W-1:0] oh;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got index %0d expected none", out_index);
            end else begin
                e  = exp_q.pop_front();
                oh = '0;
                oh[e] = 1'b1;
                check("out_index", 32'(out_index), 32'(e));
                check("inVal_onehot", 32'(inVal), 32'(oh));
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        enable    = 1'b1;
        req       = 8'hFF;
        out_ready = 1'b1;

        // Reset with requests asserted: nothing may be captured.
        step(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inVal", 32'(inVal), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;
        req   = '0;
        step();
        check("post_rst_valid", 32'(out_valid), 32'd0);

        // Single request: valid two edges after req is presented, for one cycle.
        exp_q.push_back(3'd2);
        pulse(8'h04);
        step();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_inVal", 32'(inVal), 32'h04);
        check("single_index", 32'(out_index), 32'd2);
        step();
        check("single_gone", 32'(out_valid), 32'd0);
        check("single_busy", 32'(busy), 32'd0);

        // Priority order, back-to-back with no bubble.
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd0);
        pulse(8'h81);
        step();
        check("prio81_first", 32'(out_index), 32'd7);
        check("prio81_first_v", 32'(out_valid), 32'd1);
        step();
        check("prio81_second", 32'(out_index), 32'd0);
        check("prio81_second_v", 32'(out_valid), 32'd1);
        step();
        check("prio81_idle", 32'(out_valid), 32'd0);

        exp_q.push_back(3'd7);
        exp_q.push_back(3'd1);
        pulse(8'h82);
        drain();

        // Backpressure: line 5 held stable until accepted, then 4.
        out_ready = 1'b0;
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd4);
        pulse(8'h30);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_index", 32'(out_index), 32'd5);
            check("bp_hold_inVal", 32'(inVal), 32'h20);
        end
        out_ready = 1'b1;
        drain();
        step();
        check("bp_idle", 32'(out_valid), 32'd0);

        // req and clr on the same bit in one edge: req wins, line served twice.
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd2);
        pulse(8'h04, 2);
        drain();
        step();
        check("reqclr_idle", 32'(busy), 32'd0);

        // Enable gating: requests ignored while disabled.
        enable = 1'b0;
        req    = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_off_valid", 32'(out_valid), 32'd0);
            check("en_off_busy", 32'(busy), 32'd0);
        end
        enable = 1'b1;
        exp_q.push_back(3'd4);
        pulse(8'h10);
        drain();

        // Duplicates while output stalls merge into one pending bit.
`ifdef DROP_CNT_EN
        check("drop_cnt_before", 32'(drop_cnt), 32'd0);
`endif
        out_ready = 1'b0;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd3);
        pulse(8'h80);
        step();
        for (int i = 0; i < 4; i++) begin
            pulse(8'h08);
            step();
        end
        check("dup_held_index", 32'(out_index), 32'd7);
`ifdef DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'd3);
`endif
        out_ready = 1'b1;
        drain();
        step(2);
        check("dup_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
